// File: rtl/ad9837_sweep_controller.sv
// ad9837_sweep_controller: configures an AD9837 and then steps FREQ0 from a
// start tuning word to a stop tuning word. Each frequency is held for a
// programmable number of clocks. Command words go to the SPI word serializer
// over a valid/ready handshake.
module ad9837_sweep_controller #(
  parameter logic [11:0] PHASE_WORD = 12'h000,
  parameter int unsigned DWELL_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [27:0]        f_start_i,
  input  logic [27:0]        f_stop_i,
  input  logic [27:0]        f_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [1:0]         wave_sel_i,
  input  logic               loop_i,
  output logic [15:0]        word_o,
  output logic               word_valid_o,
  input  logic               word_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [27:0]        cur_freq_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_RST,
    S_CFG_LSB,
    S_CFG_MSB,
    S_CFG_PH,
    S_CFG_RUN,
    S_DWELL,
    S_STEP_LSB,
    S_STEP_MSB,
    S_HOLD,
    S_ABORT_RST
  } state_t;

  localparam logic [15:0] W_RESET = 16'h2100;  // B28 | RESET

  state_t             state_q, state_d;

  logic [27:0]        f_start_q, f_stop_q, f_step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [1:0]         wave_q;
  logic               loop_q;

  logic [27:0]        freq_q;   // frequency being programmed
  logic [27:0]        cur_q;    // frequency loaded in the device
  logic [DWELL_W-1:0] cnt_q;
  logic               abort_pend_q;
  logic               done_q, done_d;

  logic               latch_cfg, adv_freq, wrap_freq;
  logic               accept, abort_now, dwell_last;
  logic               sweep_end, can_loop;
  logic [28:0]        nxt;
  logic [DWELL_W-1:0] dwell_load;
  logic [15:0]        run_word;

  assign accept     = word_valid_o & word_ready_i;
  assign abort_now  = abort_i | abort_pend_q;
  assign dwell_last = (cnt_q == DWELL_W'(1));
  assign dwell_load = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

  // Next tuning word, one bit wider so overflow past 28 bits ends the sweep.
  assign nxt       = {1'b0, cur_q} + {1'b0, f_step_q};
  assign sweep_end = nxt[28] | (nxt[27:0] > f_stop_q) | (f_step_q == '0);
  assign can_loop  = loop_q & (f_step_q != '0) & (f_start_q <= f_stop_q);

  // Control word that (re)enables the output with the selected waveform.
  always_comb begin
    run_word = 16'h2000;
    case (wave_q)
      2'b00:   run_word = 16'h2000;
      2'b01:   run_word = 16'h2002;
      2'b10:   run_word = 16'h2028;
      default: run_word = 16'h2020;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    adv_freq  = 1'b0;
    wrap_freq = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d   = S_CFG_RST;
          latch_cfg = 1'b1;
        end
      end
      S_CFG_RST: begin
        if (accept) state_d = abort_now ? S_ABORT_RST : S_CFG_LSB;
      end
      S_CFG_LSB: begin
        if (accept) state_d = abort_now ? S_ABORT_RST : S_CFG_MSB;
      end
      S_CFG_MSB: begin
        if (accept) state_d = abort_now ? S_ABORT_RST : S_CFG_PH;
      end
      S_CFG_PH: begin
        if (accept) state_d = abort_now ? S_ABORT_RST : S_CFG_RUN;
      end
      S_CFG_RUN: begin
        if (accept) state_d = abort_now ? S_ABORT_RST : S_DWELL;
      end
      S_DWELL: begin
        if (abort_i) begin
          state_d = S_ABORT_RST;
        end else if (dwell_last) begin
          if (!sweep_end) begin
            state_d  = S_STEP_LSB;
            adv_freq = 1'b1;
          end else if (can_loop) begin
            state_d   = S_STEP_LSB;
            wrap_freq = 1'b1;
          end else begin
            state_d = S_HOLD;
            done_d  = 1'b1;
          end
        end
      end
      S_STEP_LSB: begin
        if (accept) state_d = abort_now ? S_ABORT_RST : S_STEP_MSB;
      end
      S_STEP_MSB: begin
        if (accept) state_d = abort_now ? S_ABORT_RST : S_DWELL;
      end
      S_HOLD: begin
        if (abort_i) begin
          state_d = S_ABORT_RST;
        end else if (start_i) begin
          state_d   = S_CFG_RST;
          latch_cfg = 1'b1;
        end
      end
      S_ABORT_RST: begin
        if (accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: command word per send state, busy outside IDLE/HOLD.
  always_comb begin
    word_o       = '0;
    word_valid_o = 1'b0;
    case (state_q)
      S_CFG_RST, S_ABORT_RST: begin
        word_o       = W_RESET;
        word_valid_o = 1'b1;
      end
      S_CFG_LSB, S_STEP_LSB: begin
        word_o       = {2'b01, freq_q[13:0]};
        word_valid_o = 1'b1;
      end
      S_CFG_MSB, S_STEP_MSB: begin
        word_o       = {2'b01, freq_q[27:14]};
        word_valid_o = 1'b1;
      end
      S_CFG_PH: begin
        word_o       = {4'hC, PHASE_WORD};
        word_valid_o = 1'b1;
      end
      S_CFG_RUN: begin
        word_o       = run_word;
        word_valid_o = 1'b1;
      end
      default: ;
    endcase
    busy_o = (state_q != S_IDLE) && (state_q != S_HOLD);
  end

  assign done_o     = done_q;
  assign cur_freq_o = cur_q;

  // Datapath: latched sweep settings, frequency tracking, dwell timer, abort latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_start_q    <= '0;
      f_stop_q     <= '0;
      f_step_q     <= '0;
      dwell_q      <= '0;
      wave_q       <= '0;
      loop_q       <= 1'b0;
      freq_q       <= '0;
      cur_q        <= '0;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= done_d;

      if (latch_cfg) begin
        f_start_q <= f_start_i;
        f_stop_q  <= f_stop_i;
        f_step_q  <= f_step_i;
        dwell_q   <= dwell_i;
        wave_q    <= wave_sel_i;
        loop_q    <= loop_i;
        freq_q    <= f_start_i;
      end else if (wrap_freq) begin
        freq_q <= f_start_q;
      end else if (adv_freq) begin
        freq_q <= nxt[27:0];
      end

      if (accept && (state_q == S_CFG_MSB || state_q == S_STEP_MSB)) begin
        cur_q <= freq_q;
      end

      if (state_d == S_DWELL && state_q != S_DWELL) begin
        cnt_q <= dwell_load;
      end else if (state_q == S_DWELL && cnt_q != '0) begin
        cnt_q <= cnt_q - DWELL_W'(1);
      end

      // An abort seen while a word is pending is held until that word is accepted.
      if (accept) begin
        abort_pend_q <= 1'b0;
      end else if (word_valid_o && abort_i) begin
        abort_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ad9837_sweep_controller.sv
// tb_ad9837_sweep_controller: table-driven, randomized and hand-written
// sequences checked against a frequency-list model of the sweep.
module tb_ad9837_sweep_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, start_i, abort_i, loop_i, word_ready_i;
  logic [27:0] f_start_i, f_stop_i, f_step_i;
  logic [31:0] dwell_i;
  logic [1:0]  wave_sel_i;
  logic [15:0] word_o;
  logic        word_valid_o, busy_o, done_o;
  logic [27:0] cur_freq_o;

  ad9837_sweep_controller #(
    .PHASE_WORD (12'h000),
    .DWELL_W    (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .f_start_i    (f_start_i),
    .f_stop_i     (f_stop_i),
    .f_step_i     (f_step_i),
    .dwell_i      (dwell_i),
    .wave_sel_i   (wave_sel_i),
    .loop_i       (loop_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cur_freq_o   (cur_freq_o)
  );

  typedef struct {
    logic [27:0] fs;
    logic [27:0] fe;
    logic [27:0] st;
    logic [31:0] dw;
    logic [1:0]  wv;
    logic        lp;
    int unsigned rm;       // 0 ready=1, 1 one-in-three, 2 random, 3 manual
    int unsigned x_words;
    logic [27:0] x_cur;
    int unsigned x_done;
  } vec_t;

  int unsigned pass_cnt = 0, total_cnt = 0;
  int unsigned cyc = 0;
  int unsigned rmode = 0;
  int unsigned done_cnt = 0, stab_err = 0;
  logic [15:0] got_q[$];
  int unsigned got_t[$];
  logic [15:0] exp_q[$];
  logic [27:0] m_cur;
  logic        pv = 1'b0, pr = 1'b0;
  logic [15:0] pw = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern, changed only just after the active edge.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: word_ready_i = 1'b1;
      1: word_ready_i = (cyc % 3 == 0);
      2: word_ready_i = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: records words that will transfer on the coming edge, done pulses,
  // and any change of a stalled word.
  always @(negedge clk) begin
    if (rst_i) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!word_valid_o || word_o != pw)) stab_err++;
      if (word_valid_o && word_ready_i) begin
        got_q.push_back(word_o);
        got_t.push_back(cyc);
      end
      if (done_o) done_cnt++;
      pv = word_valid_o;
      pr = word_ready_i;
      pw = word_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] run_word(input logic [1:0] w);
    case (w)
      2'b00:   return 16'h2000;
      2'b01:   return 16'h2002;
      2'b10:   return 16'h2028;
      default: return 16'h2020;
    endcase
  endfunction

  function automatic void push_freq(input logic [27:0] f);
    exp_q.push_back({2'b01, f[13:0]});
    exp_q.push_back({2'b01, f[27:14]});
  endfunction

  // Reference: list every frequency start + k*step that does not exceed stop,
  // emit the configuration, then visit the list (cyclically when looping).
  function automatic void build_model(input vec_t v, input int unsigned limit);
    longint unsigned fl[$];
    longint unsigned f;
    int unsigned n, k;
    exp_q.delete();
    fl.push_back(64'(v.fs));
    if (v.st != 0 && v.fs <= v.fe) begin
      f = 64'(v.fs) + 64'(v.st);
      while (f <= 64'(v.fe)) begin
        fl.push_back(f);
        f = f + 64'(v.st);
      end
    end
    exp_q.push_back(16'h2100);
    push_freq(v.fs);
    exp_q.push_back(16'hC000);
    exp_q.push_back(run_word(v.wv));
    n = fl.size();
    if (v.lp && v.st != 0 && v.fs <= v.fe) begin
      k = 1;
      while (exp_q.size() < limit) begin
        push_freq(28'(fl[k % n]));
        k++;
      end
    end else begin
      for (k = 1; k < n; k++) push_freq(28'(fl[k]));
    end
    m_cur = 28'(fl[n-1]);
  endfunction

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    done_cnt = 0;
    stab_err = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    clear_mon();
  endtask

  task automatic pulse_start(input vec_t v);
    @(posedge clk); #1;
    f_start_i  = v.fs;
    f_stop_i   = v.fe;
    f_step_i   = v.st;
    dwell_i    = v.dw;
    wave_sel_i = v.wv;
    loop_i     = v.lp;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i    = 1'b0;
    f_start_i  = 28'($urandom);
    f_stop_i   = 28'($urandom);
    f_step_i   = 28'($urandom);
    dwell_i    = 32'($urandom_range(0, 3));
    wave_sel_i = 2'($urandom);
    loop_i     = 1'($urandom);
  endtask

  task automatic wait_not_busy(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " finished"}, 32'(n < budget), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cmp_stream(input string name, input int unsigned len);
    int unsigned m = 0;
    string nm;
    while (m < len && m < got_q.size() && m < exp_q.size() && got_q[m] == exp_q[m]) m++;
    nm = {name, " stream prefix"};
    if (m < len && m < got_q.size() && m < exp_q.size())
      nm = $sformatf("%s stream (word %0d got %h exp %h)", name, m, got_q[m], exp_q[m]);
    check(nm, m, len);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    clear_mon();
    rmode = v.rm;
    build_model(v, 0);
    pulse_start(v);
    wait_not_busy(name, 8000);
    check({name, " nwords"}, 32'(got_q.size()), v.x_words);
    cmp_stream(name, exp_q.size());
    check({name, " cur_freq"}, 32'(cur_freq_o), 32'(v.x_cur));
    check({name, " done pulses"}, done_cnt, v.x_done);
    check({name, " stall stable"}, stab_err, 32'd0);
    if (v.rm == 0 && got_t.size() > 5)
      check({name, " dwell gap"}, got_t[5] - got_t[4], ((v.dw == 0) ? 32'd1 : v.dw) + 32'd1);
  endtask

  initial begin
    vec_t tbl[7];
    string tnames[7];
    vec_t rv;
    longint unsigned e;
    int unsigned kind, k, n;
    logic [15:0] msbw;

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; word_ready_i = 1'b1;
    f_start_i = '0; f_stop_i = '0; f_step_i = '0; dwell_i = '0;
    wave_sel_i = '0; loop_i = 1'b0;

    tbl[0] = '{fs:28'h0000ABC, fe:28'h0000ABC, st:28'h0, dw:32'd3, wv:2'd0, lp:1'b0, rm:0,
               x_words:5, x_cur:28'h0000ABC, x_done:1};
    tbl[1] = '{fs:28'h0004000, fe:28'h0004300, st:28'h100, dw:32'd10, wv:2'd1, lp:1'b0, rm:0,
               x_words:11, x_cur:28'h0004300, x_done:1};
    tbl[2] = '{fs:28'h0000ABC, fe:28'h0000ABC, st:28'h0, dw:32'd3, wv:2'd0, lp:1'b0, rm:1,
               x_words:5, x_cur:28'h0000ABC, x_done:1};
    tbl[3] = '{fs:28'h0005000, fe:28'h0004000, st:28'h10, dw:32'd2, wv:2'd2, lp:1'b1, rm:0,
               x_words:5, x_cur:28'h0005000, x_done:1};
    tbl[4] = '{fs:28'h0000123, fe:28'hFFFFFFF, st:28'h0, dw:32'd0, wv:2'd3, lp:1'b1, rm:0,
               x_words:5, x_cur:28'h0000123, x_done:1};
    tbl[5] = '{fs:28'hFFFFFF0, fe:28'hFFFFFFF, st:28'h8, dw:32'd1, wv:2'd0, lp:1'b0, rm:0,
               x_words:7, x_cur:28'hFFFFFF8, x_done:1};
    tbl[6] = '{fs:28'h1234567, fe:28'h153A5F7, st:28'h0102030, dw:32'd4, wv:2'd1, lp:1'b0, rm:2,
               x_words:11, x_cur:28'h153A5F7, x_done:1};
    tnames = '{"basic", "sweep", "backpressure", "start>stop", "step0", "ovf_end", "multi"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset word_o", 32'(word_o), 32'd0);
    check("reset valid", 32'(word_valid_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset cur_freq", 32'(cur_freq_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], tnames[i]);

    for (int i = 0; i < 10; i++) begin
      kind  = $urandom_range(0, 5);
      rv.fs = 28'($urandom);
      rv.st = 28'($urandom_range(1, 32'h00FFFFFF));
      rv.lp = 1'b0;
      k     = $urandom_range(0, 4);
      e     = 64'(rv.fs) + 64'(k) * 64'(rv.st) + 64'($urandom_range(0, 32'(rv.st) - 1));
      if (e > 64'h0FFFFFFF) e = 64'h0FFFFFFF;
      rv.fe = 28'(e);
      if (kind == 0) begin
        rv.st = '0;
        rv.lp = 1'($urandom);
      end else if (kind == 1) begin
        rv.fs = 28'($urandom_range(16, 32'h0FFFFFFF));
        rv.fe = rv.fs - 28'($urandom_range(1, 15));
        rv.lp = 1'($urandom);
      end
      rv.dw = 32'($urandom_range(0, 6));
      rv.wv = 2'($urandom);
      rv.rm = $urandom_range(0, 2);
      build_model(rv, 0);
      rv.x_words = exp_q.size();
      rv.x_cur   = m_cur;
      rv.x_done  = 1;
      run_vec(rv, $sformatf("rand%0d", i));
    end

    // Loop with overflow: wraps back to the start word, never finishes.
    do_reset();
    rmode = 0;
    rv = '{fs:28'hFFFFF00, fe:28'hFFFFFFF, st:28'h80, dw:32'd2, wv:2'd1, lp:1'b1, rm:0,
           x_words:11, x_cur:28'h0, x_done:0};
    build_model(rv, 11);
    pulse_start(rv);
    n = 0;
    while (got_q.size() < 11 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("loop reached 11 words", 32'(n < 400), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    cmp_stream("loop", 11);
    check("loop done pulses", done_cnt, 32'd0);
    check("loop busy", 32'(busy_o), 32'd1);

    // Abort while the configuration MSB word is stalled.
    do_reset();
    rmode = 3;
    word_ready_i = 1'b1;
    rv = '{fs:28'h2ABCDEF, fe:28'h2ABCDEF, st:28'h0, dw:32'd3, wv:2'd2, lp:1'b0, rm:3,
           x_words:4, x_cur:28'h2ABCDEF, x_done:0};
    msbw = {2'b01, rv.fs[27:14]};
    pulse_start(rv);
    n = 0;
    while (!(word_valid_o && word_o == msbw) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    word_ready_i = 1'b0;
    check("abort msb pending", 32'(n < 50), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort valid held", 32'(word_valid_o), 32'd1);
    check("abort word held", 32'(word_o), 32'(msbw));
    word_ready_i = 1'b1;
    wait_not_busy("abort", 100);
    exp_q.delete();
    exp_q.push_back(16'h2100);
    exp_q.push_back({2'b01, rv.fs[13:0]});
    exp_q.push_back(msbw);
    exp_q.push_back(16'h2100);
    check("abort nwords", 32'(got_q.size()), rv.x_words);
    cmp_stream("abort", 4);
    check("abort done pulses", done_cnt, rv.x_done);
    check("abort cur_freq", 32'(cur_freq_o), 32'(rv.x_cur));
    check("abort stall stable", stab_err, 32'd0);

    // Start during dwell is ignored; reset during STEP_LSB clears everything.
    do_reset();
    rmode = 0;
    rv = tbl[1];
    pulse_start(rv);
    n = 0;
    while (got_q.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    f_start_i = 28'h1111111;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i   = 1'b0;
    n = 0;
    while (!(word_valid_o && word_o == 16'h4100) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("step lsb reached", 32'(n < 100), 32'd1);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst word_o", 32'(word_o), 32'd0);
    check("rst valid", 32'(word_valid_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst cur_freq", 32'(cur_freq_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    build_model(rv, 0);
    check("pre-reset nwords", 32'(got_q.size()), 32'd5);
    cmp_stream("pre-reset", 5);
    repeat (3) @(posedge clk);
    #1;
    check("idle after reset busy", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ad9837_sweep_controller.md
Name: ad9837_sweep_controller

Overview:
- Sequences the AD9837 waveform generator: on start, issues the full configuration word sequence, then steps FREQ0 from a start value to a stop value with a programmable dwell per step.
- Produces 16-bit command words over a valid/ready handshake to the downstream AD9837 SPI word serializer (fsync/sclk/sdata).
- Sits between the system control registers and the serializer, which it owns exclusively.

Parameters:
- PHASE_WORD, 12'h000, PHASE0 value written during configuration.
- DWELL_W, 32, width of the dwell counter and of dwell_i.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle start pulse
- abort_i  in  1  one-cycle abort pulse
- f_start_i  in  28  first FREQ0 tuning word
- f_stop_i  in  28  last permitted tuning word (inclusive)
- f_step_i  in  28  increment per step
- dwell_i  in  DWELL_W  clocks to hold each frequency
- wave_sel_i  in  2  00 sine, 01 triangle, 10 square MSB, 11 square MSB/2
- loop_i  in  1  1 = restart from f_start after stop is passed
- word_o  out  16  command word to serializer
- word_valid_o  out  1  word_o valid
- word_ready_i  in  1  serializer accepts word
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at sweep end
- cur_freq_o  out  28  tuning word currently loaded in the device

Behaviour:
- Reset: all outputs 0; state IDLE. A reset mid-handshake drops the word immediately.
- Handshake: a word transfers on the rising edge where word_valid_o && word_ready_i. word_o is stable while valid is high and not yet accepted. Back-to-back transfers are allowed (the next word is presented in the cycle after acceptance).
- Latching: f_start/f_stop/f_step/dwell/wave_sel/loop are captured on an accepted start_i. Later input changes have no effect until the next start.
- Run word RUN: wave_sel 00 = 0x2000, 01 = 0x2002, 10 = 0x2028, 11 = 0x2020.
- States and words:
  - IDLE: start_i goes to CFG_RST.
  - CFG_RST: sends 0x2100 (B28 plus RESET).
  - CFG_LSB: sends 0x4000 | f[13:0].
  - CFG_MSB: sends 0x4000 | f[27:14].
  - CFG_PH: sends 0xC000 | PHASE_WORD.
  - CFG_RUN: sends RUN, then goes to DWELL.
  - DWELL: counter loads dwell_i on entry; stays max(dwell_i,1) cycles, then evaluates the next frequency.
  - STEP_LSB / STEP_MSB: send the new LSB/MSB words, then go to DWELL.
  - HOLD: output stays active at the last frequency.
  - ABORT_RST: sends 0x2100, then goes to IDLE.
- cur_freq_o updates on acceptance of the MSB word (CFG_MSB or STEP_MSB).
- Next-frequency rule: nxt = cur + step, computed 29 bits wide. The sweep ends if nxt[28] is set, or nxt > f_stop, or step == 0.
  - End with loop_i = 1 and step != 0: cur := f_start, go to STEP_LSB.
  - End otherwise: pulse done_o, go to HOLD.
- f_start > f_stop: the configuration completes at f_start, one dwell runs, then done_o pulses and the block enters HOLD (loop ignored).
- busy_o = 1 in every state except IDLE and HOLD.
- start_i in HOLD restarts the sequence from CFG_RST. start_i while busy is ignored.
- Abort:
  - In DWELL or HOLD: go to ABORT_RST next cycle.
  - In a send state: latched; the pending word is kept until accepted, then the block goes to ABORT_RST.
  - In IDLE: ignored.
  - done_o is not pulsed on abort.
  - start_i and abort_i in the same cycle: abort wins (IDLE start is ignored).
- word_valid_o never deasserts while a word is pending, including when abort_i arrives.

Test Plan:
- Basic config: f_start=0x0000ABC, f_stop=0x0000ABC, step=0, sine, ready held 1 -> words 0x2100, 0x4ABC, 0x4000, 0xC000, 0x2000 on consecutive cycles; dwell, then done_o pulse, HOLD, cur_freq_o=0x0000ABC, busy_o=0.
- Sweep: start=0x4000, stop=0x4300, step=0x100, dwell=10, triangle -> config ends with 0x2002. Then LSB/MSB pairs for 0x4100, 0x4200, 0x4300, each separated by 10 dwell cycles. done_o fires after the 0x4300 dwell.
- Loop and overflow: start=0xFFFFF00, stop=0xFFFFFFF, step=0x80, loop=1 -> 0xFFFFF80 is written, then nxt overflows, block wraps to 0xFFFFF00. No done_o; busy_o stays 1.
- Backpressure: word_ready_i toggles 1-in-3 -> word_o and word_valid_o are held stable until acceptance; no word is skipped or duplicated; sequence is identical to the basic case.
- Abort mid-handshake: ready=0 while CFG_MSB is pending, then pulse abort_i, then ready=1 -> the MSB word is accepted, then 0x2100, then IDLE, busy_o=0, done_o never asserted.
- Reset during STEP_LSB, and start during busy -> after reset all outputs are 0 and the block is in IDLE. A start_i during DWELL does not restart the sequence.
